id_ex_pipe_reg: RTL and testbench

//  ID/EX pipeline register directly downstream of ctrl_unit: captures decoded control bundle,

---
 rtl/id_ex_pipe_reg_pkg.sv | 44 ++++
 rtl/id_ex_pipe_reg_load_use_detect.sv | 34 +++
 rtl/id_ex_pipe_reg.sv | 203 ++++++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the decode/execute boundary.
// Holds the ALU operation encodings, memory access size codes, the decoded
// control bundle struct and the all-zero bubble constant. The same package is
// imported by ctrl_unit and the EX stage so every block agrees on encodings.
package id_ex_pipe_reg_pkg;

    // ALU operation encodings (5 bits)
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SLL  = 5'b00101;
    localparam logic [4:0] ALU_SRL  = 5'b00110;
    localparam logic [4:0] ALU_SRA  = 5'b00111;
    localparam logic [4:0] ALU_BEQ  = 5'b01000;
    localparam logic [4:0] ALU_SLT  = 5'b01001;
    localparam logic [4:0] ALU_SLTU = 5'b01010;

    // Memory access size codes, shared by MEM_READ and MEM_WRITE
    localparam logic [2:0] NO_MEM  = 3'b000;
    localparam logic [2:0] MEM_B   = 3'b001;
    localparam logic [2:0] MEM_H   = 3'b010;
    localparam logic [2:0] MEM_W   = 3'b011;
    localparam logic [2:0] MEM_BU  = 3'b100;
    localparam logic [2:0] MEM_HU  = 3'b101;

    // Decoded control bundle as produced by ctrl_unit
    typedef struct packed {
        logic [4:0] alu_op;
        logic [2:0] mem_read;
        logic [2:0] mem_write;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_source;
        logic       reg_write;
        logic       branch;
        logic       reg_dest;
        logic       pc_sel;
    } ctrl_t;

    // A bubble has no architectural side effect: no write, no memory, no branch
    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Load-use hazard detector (purely combinational).
// Flags when the instruction in EX is a valid load that writes a non-zero
// destination register read by the instruction currently in ID.
// Ports:
//   ex_valid_i       EX holds a real instruction
//   ex_mem_read_i    load size code of the EX instruction (NO_MEM = not a load)
//   ex_reg_write_i   EX instruction writes the register file
//   ex_rd_i          destination register of the EX instruction
//   id_rs1_i/rs2_i   source registers of the ID instruction
//   load_use_stall_o IF/ID and PC must hold this cycle
module load_use_detect
    import id_ex_pipe_reg_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic [2:0] ex_mem_read_i,
    input  logic       ex_reg_write_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    output logic       load_use_stall_o
);

    logic ex_is_load;
    logic rd_match;

    assign ex_is_load = ex_valid_i && (ex_mem_read_i != NO_MEM) && ex_reg_write_i
                        && (ex_rd_i != 5'd0);
    // rs2 is compared even for instructions that do not read it; a spurious
    // stall costs one cycle but avoids decoding operand usage here.
    assign rd_match   = (ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i);

    assign load_use_stall_o = ex_is_load && rd_match;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register.
// Captures the decoded control bundle, operands, immediate and register
// addresses from ID each rising edge and presents them to EX one cycle later.
// Inserts a bubble on FLUSH (branch/JALR redirect) or on a load-use hazard,
// holds everything on STALL, and counts inserted bubbles (saturating).
// Ports:
//   CLK, RESET                 clock, async active-high reset
//   STALL, FLUSH               hold / bubble requests (FLUSH wins)
//   ID_*                       control bundle, funct3, PC, operands, imm, reg addrs
//   EX_*                       registered copies of ID_*
//   EX_VALID                   0 when EX holds a bubble
//   LOAD_USE_STALL             combinational hazard flag for IF/ID and PC
//   BUBBLE_COUNT               bubbles inserted since reset (saturating)
module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic [4:0]        ID_ALU_OP,
    input  logic [2:0]        ID_MEM_READ,
    input  logic [2:0]        ID_MEM_WRITE,
    input  logic [1:0]        ID_MEM_TO_REG,
    input  logic [1:0]        ID_ALU_SOURCE,
    input  logic              ID_REG_WRITE,
    input  logic              ID_BRANCH,
    input  logic              ID_REG_DEST,
    input  logic              ID_PC_SEL,
    input  logic [2:0]        ID_FUN3,
    input  logic [DATA_W-1:0] ID_PC,
    input  logic [DATA_W-1:0] ID_RS1_DATA,
    input  logic [DATA_W-1:0] ID_RS2_DATA,
    input  logic [DATA_W-1:0] ID_IMM,
    input  logic [4:0]        ID_RS1,
    input  logic [4:0]        ID_RS2,
    input  logic [4:0]        ID_RD,
    output logic [4:0]        EX_ALU_OP,
    output logic [2:0]        EX_MEM_READ,
    output logic [2:0]        EX_MEM_WRITE,
    output logic [1:0]        EX_MEM_TO_REG,
    output logic [1:0]        EX_ALU_SOURCE,
    output logic              EX_REG_WRITE,
    output logic              EX_BRANCH,
    output logic              EX_REG_DEST,
    output logic              EX_PC_SEL,
    output logic [2:0]        EX_FUN3,
    output logic [DATA_W-1:0] EX_PC,
    output logic [DATA_W-1:0] EX_RS1_DATA,
    output logic [DATA_W-1:0] EX_RS2_DATA,
    output logic [DATA_W-1:0] EX_IMM,
    output logic [4:0]        EX_RS1,
    output logic [4:0]        EX_RS2,
    output logic [4:0]        EX_RD,
    output logic              EX_VALID,
    output logic              LOAD_USE_STALL,
    output logic [CNT_W-1:0]  BUBBLE_COUNT
);

    ctrl_t              id_ctrl;
    ctrl_t              ctrl_q,     ctrl_d;
    logic [2:0]         fun3_q,     fun3_d;
    logic [DATA_W-1:0]  pc_q,       pc_d;
    logic [DATA_W-1:0]  rs1_data_q, rs1_data_d;
    logic [DATA_W-1:0]  rs2_data_q, rs2_data_d;
    logic [DATA_W-1:0]  imm_q,      imm_d;
    logic [4:0]         rs1_q,      rs1_d;
    logic [4:0]         rs2_q,      rs2_d;
    logic [4:0]         rd_q,       rd_d;
    logic               valid_q,    valid_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               load_use;
    logic               insert_bubble;

    assign id_ctrl = '{
        alu_op:     ID_ALU_OP,
        mem_read:   ID_MEM_READ,
        mem_write:  ID_MEM_WRITE,
        mem_to_reg: ID_MEM_TO_REG,
        alu_source: ID_ALU_SOURCE,
        reg_write:  ID_REG_WRITE,
        branch:     ID_BRANCH,
        reg_dest:   ID_REG_DEST,
        pc_sel:     ID_PC_SEL
    };

    // Hazard check looks at the registered EX contents, so the only
    // combinational path from ID_* ends at LOAD_USE_STALL.
    load_use_detect u_load_use_detect (
        .ex_valid_i       (valid_q),
        .ex_mem_read_i    (ctrl_q.mem_read),
        .ex_reg_write_i   (ctrl_q.reg_write),
        .ex_rd_i          (rd_q),
        .id_rs1_i         (ID_RS1),
        .id_rs2_i         (ID_RS2),
        .load_use_stall_o (load_use)
    );

    // Priority: FLUSH > STALL > load-use > normal capture
    always_comb begin
        ctrl_d        = ctrl_q;
        fun3_d        = fun3_q;
        pc_d          = pc_q;
        rs1_data_d    = rs1_data_q;
        rs2_data_d    = rs2_data_q;
        imm_d         = imm_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rd_d          = rd_q;
        valid_d       = valid_q;
        cnt_d         = cnt_q;
        insert_bubble = 1'b0;

        if (FLUSH) begin
            insert_bubble = 1'b1;
        end else if (STALL) begin
            insert_bubble = 1'b0;
        end else if (load_use) begin
            insert_bubble = 1'b1;
        end else begin
            ctrl_d     = id_ctrl;
            fun3_d     = ID_FUN3;
            pc_d       = ID_PC;
            rs1_data_d = ID_RS1_DATA;
            rs2_data_d = ID_RS2_DATA;
            imm_d      = ID_IMM;
            rs1_d      = ID_RS1;
            rs2_d      = ID_RS2;
            rd_d       = ID_RD;
            valid_d    = 1'b1;
        end

        if (insert_bubble) begin
            ctrl_d     = BUBBLE;
            fun3_d     = '0;
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            valid_d    = 1'b0;
            // Saturate rather than wrap so a long run never reports a small count
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ctrl_q     <= BUBBLE;
            fun3_q     <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            fun3_q     <= fun3_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign EX_ALU_OP      = ctrl_q.alu_op;
    assign EX_MEM_READ    = ctrl_q.mem_read;
    assign EX_MEM_WRITE   = ctrl_q.mem_write;
    assign EX_MEM_TO_REG  = ctrl_q.mem_to_reg;
    assign EX_ALU_SOURCE  = ctrl_q.alu_source;
    assign EX_REG_WRITE   = ctrl_q.reg_write;
    assign EX_BRANCH      = ctrl_q.branch;
    assign EX_REG_DEST    = ctrl_q.reg_dest;
    assign EX_PC_SEL      = ctrl_q.pc_sel;
    assign EX_FUN3        = fun3_q;
    assign EX_PC          = pc_q;
    assign EX_RS1_DATA    = rs1_data_q;
    assign EX_RS2_DATA    = rs2_data_q;
    assign EX_IMM         = imm_q;
    assign EX_RS1         = rs1_q;
    assign EX_RS2         = rs2_q;
    assign EX_RD          = rd_q;
    assign EX_VALID       = valid_q;
    assign LOAD_USE_STALL = load_use;
    assign BUBBLE_COUNT   = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios followed by random traffic,
// checked against a transaction-level model of the EX stage contents.
// A second instance with a 2-bit counter exercises saturation.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic [4:0]  alu_op;
        logic [2:0]  mem_read;
        logic [2:0]  mem_write;
        logic [1:0]  mem_to_reg;
        logic [1:0]  alu_source;
        logic        reg_write;
        logic        branch;
        logic        reg_dest;
        logic        pc_sel;
        logic [2:0]  fun3;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } stage_t;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    // ---------------- DUT signals ----------------
    logic STALL, FLUSH;
    logic [4:0]  ID_ALU_OP;
    logic [2:0]  ID_MEM_READ, ID_MEM_WRITE, ID_FUN3;
    logic [1:0]  ID_MEM_TO_REG, ID_ALU_SOURCE;
    logic        ID_REG_WRITE, ID_BRANCH, ID_REG_DEST, ID_PC_SEL;
    logic [31:0] ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
    logic [4:0]  ID_RS1, ID_RS2, ID_RD;

    logic [4:0]  EX_ALU_OP, s_alu_op;
    logic [2:0]  EX_MEM_READ, EX_MEM_WRITE, EX_FUN3, s_mem_read, s_mem_write, s_fun3;
    logic [1:0]  EX_MEM_TO_REG, EX_ALU_SOURCE, s_mem_to_reg, s_alu_source;
    logic        EX_REG_WRITE, EX_BRANCH, EX_REG_DEST, EX_PC_SEL;
    logic        s_reg_write, s_branch, s_reg_dest, s_pc_sel;
    logic [31:0] EX_PC, EX_RS1_DATA, EX_RS2_DATA, EX_IMM;
    logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
    logic [4:0]  EX_RS1, EX_RS2, EX_RD, s_rs1, s_rs2, s_rd;
    logic        EX_VALID, LOAD_USE_STALL, s_valid, s_lus;
    logic [15:0] BUBBLE_COUNT;
    logic [1:0]  s_count;

    id_ex_pipe_reg #(.DATA_W(32), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
        .ID_ALU_OP(ID_ALU_OP), .ID_MEM_READ(ID_MEM_READ), .ID_MEM_WRITE(ID_MEM_WRITE),
        .ID_MEM_TO_REG(ID_MEM_TO_REG), .ID_ALU_SOURCE(ID_ALU_SOURCE),
        .ID_REG_WRITE(ID_REG_WRITE), .ID_BRANCH(ID_BRANCH), .ID_REG_DEST(ID_REG_DEST),
        .ID_PC_SEL(ID_PC_SEL), .ID_FUN3(ID_FUN3), .ID_PC(ID_PC),
        .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA), .ID_IMM(ID_IMM),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD),
        .EX_ALU_OP(EX_ALU_OP), .EX_MEM_READ(EX_MEM_READ), .EX_MEM_WRITE(EX_MEM_WRITE),
        .EX_MEM_TO_REG(EX_MEM_TO_REG), .EX_ALU_SOURCE(EX_ALU_SOURCE),
        .EX_REG_WRITE(EX_REG_WRITE), .EX_BRANCH(EX_BRANCH), .EX_REG_DEST(EX_REG_DEST),
        .EX_PC_SEL(EX_PC_SEL), .EX_FUN3(EX_FUN3), .EX_PC(EX_PC),
        .EX_RS1_DATA(EX_RS1_DATA), .EX_RS2_DATA(EX_RS2_DATA), .EX_IMM(EX_IMM),
        .EX_RS1(EX_RS1), .EX_RS2(EX_RS2), .EX_RD(EX_RD), .EX_VALID(EX_VALID),
        .LOAD_USE_STALL(LOAD_USE_STALL), .BUBBLE_COUNT(BUBBLE_COUNT)
    );

    id_ex_pipe_reg #(.DATA_W(32), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
        .ID_ALU_OP(ID_ALU_OP), .ID_MEM_READ(ID_MEM_READ), .ID_MEM_WRITE(ID_MEM_WRITE),
        .ID_MEM_TO_REG(ID_MEM_TO_REG), .ID_ALU_SOURCE(ID_ALU_SOURCE),
        .ID_REG_WRITE(ID_REG_WRITE), .ID_BRANCH(ID_BRANCH), .ID_REG_DEST(ID_REG_DEST),
        .ID_PC_SEL(ID_PC_SEL), .ID_FUN3(ID_FUN3), .ID_PC(ID_PC),
        .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA), .ID_IMM(ID_IMM),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD),
        .EX_ALU_OP(s_alu_op), .EX_MEM_READ(s_mem_read), .EX_MEM_WRITE(s_mem_write),
        .EX_MEM_TO_REG(s_mem_to_reg), .EX_ALU_SOURCE(s_alu_source),
        .EX_REG_WRITE(s_reg_write), .EX_BRANCH(s_branch), .EX_REG_DEST(s_reg_dest),
        .EX_PC_SEL(s_pc_sel), .EX_FUN3(s_fun3), .EX_PC(s_pc),
        .EX_RS1_DATA(s_rs1_data), .EX_RS2_DATA(s_rs2_data), .EX_IMM(s_imm),
        .EX_RS1(s_rs1), .EX_RS2(s_rs2), .EX_RD(s_rd), .EX_VALID(s_valid),
        .LOAD_USE_STALL(s_lus), .BUBBLE_COUNT(s_count)
    );

    stage_t id_b, dut_b, sat_b;
    assign id_b  = {ID_ALU_OP, ID_MEM_READ, ID_MEM_WRITE, ID_MEM_TO_REG, ID_ALU_SOURCE,
                    ID_REG_WRITE, ID_BRANCH, ID_REG_DEST, ID_PC_SEL, ID_FUN3, ID_PC,
                    ID_RS1_DATA, ID_RS2_DATA, ID_IMM, ID_RS1, ID_RS2, ID_RD};
    assign dut_b = {EX_ALU_OP, EX_MEM_READ, EX_MEM_WRITE, EX_MEM_TO_REG, EX_ALU_SOURCE,
                    EX_REG_WRITE, EX_BRANCH, EX_REG_DEST, EX_PC_SEL, EX_FUN3, EX_PC,
                    EX_RS1_DATA, EX_RS2_DATA, EX_IMM, EX_RS1, EX_RS2, EX_RD};
    assign sat_b = {s_alu_op, s_mem_read, s_mem_write, s_mem_to_reg, s_alu_source,
                    s_reg_write, s_branch, s_reg_dest, s_pc_sel, s_fun3, s_pc,
                    s_rs1_data, s_rs2_data, s_imm, s_rs1, s_rs2, s_rd};

    // ---------------- reference model ----------------
    stage_t m_ex;
    logic   m_valid;
    int     m_cnt;
    int     m_cnt_sat;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic model_hazard();
        return m_valid && (m_ex.mem_read != 3'b000) && m_ex.reg_write && (m_ex.rd != 5'd0)
               && ((m_ex.rd == ID_RS1) || (m_ex.rd == ID_RS2));
    endfunction

    task automatic model_reset();
        m_ex      = '0;
        m_valid   = 1'b0;
        m_cnt     = 0;
        m_cnt_sat = 0;
    endtask

    task automatic model_bubble();
        m_ex      = '0;
        m_valid   = 1'b0;
        m_cnt     = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        m_cnt_sat = (m_cnt_sat < 3) ? m_cnt_sat + 1 : 3;
    endtask

    // Called just before the rising edge with the inputs that edge will see
    task automatic model_edge();
        if (FLUSH)              model_bubble();
        else if (STALL)         ;
        else if (model_hazard()) model_bubble();
        else begin
            m_ex    = id_b;
            m_valid = 1'b1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_ex"},        192'(dut_b),        192'(m_ex));
        chk({tag, "_valid"},     192'(EX_VALID),     192'(m_valid));
        chk({tag, "_count"},     192'(BUBBLE_COUNT), 192'(m_cnt));
        chk({tag, "_sat_ex"},    192'(sat_b),        192'(m_ex));
        chk({tag, "_sat_count"}, 192'(s_count),      192'(m_cnt_sat));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        STALL = 0; FLUSH = 0;
        {ID_ALU_OP, ID_MEM_READ, ID_MEM_WRITE, ID_MEM_TO_REG, ID_ALU_SOURCE,
         ID_REG_WRITE, ID_BRANCH, ID_REG_DEST, ID_PC_SEL, ID_FUN3, ID_PC,
         ID_RS1_DATA, ID_RS2_DATA, ID_IMM, ID_RS1, ID_RS2, ID_RD} = '0;
    endtask

    task automatic drive_random();
        ID_ALU_OP     = 5'($urandom_range(0, 31));
        ID_MEM_READ   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 5)) : 3'b000;
        ID_MEM_WRITE  = 3'($urandom_range(0, 7));
        ID_MEM_TO_REG = 2'($urandom_range(0, 3));
        ID_ALU_SOURCE = 2'($urandom_range(0, 3));
        ID_REG_WRITE  = 1'($urandom_range(0, 1));
        ID_BRANCH     = 1'($urandom_range(0, 1));
        ID_REG_DEST   = 1'($urandom_range(0, 1));
        ID_PC_SEL     = 1'($urandom_range(0, 1));
        ID_FUN3       = 3'($urandom_range(0, 7));
        ID_PC         = $urandom;
        ID_RS1_DATA   = $urandom;
        ID_RS2_DATA   = $urandom;
        ID_IMM        = $urandom;
        ID_RS1        = 5'($urandom_range(0, 3));
        ID_RS2        = 5'($urandom_range(0, 3));
        ID_RD         = 5'($urandom_range(0, 3));
    endtask

    // Entered just after a falling edge with inputs already driven
    task automatic step(input string tag);
        #1;
        chk({tag, "_lus"}, 192'(LOAD_USE_STALL), 192'(model_hazard()));
        model_edge();
        @(posedge CLK);
        #1;
        check_all(tag);
        @(negedge CLK);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive_idle();
        RESET = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        @(negedge CLK);
        RESET = 1'b0;

        // 1: reset between edges with a real instruction in EX
        ID_ALU_OP = 5'b00000; ID_REG_WRITE = 1; ID_RS1 = 1; ID_RS2 = 2; ID_RD = 3;
        ID_PC = 32'h100; ID_RS1_DATA = 32'hA; ID_RS2_DATA = 32'hB;
        step("add_load");
        #2 RESET = 1'b1;
        #1;
        model_reset();
        check_all("reset_mid");
        chk("reset_mid_valid_direct", 192'(EX_VALID), 192'(0));
        @(negedge CLK);
        RESET = 1'b0;

        // 2: pass-through
        drive_idle();
        ID_RS1_DATA = 32'h1234; ID_IMM = 32'hFFFF_FFF0; ID_ALU_SOURCE = 2'b01;
        ID_RD = 7; ID_REG_WRITE = 1;
        step("pass");
        chk("pass_rs1_data", 192'(EX_RS1_DATA), 192'(32'h1234));
        chk("pass_imm", 192'(EX_IMM), 192'(32'hFFFF_FFF0));
        chk("pass_alu_src", 192'(EX_ALU_SOURCE), 192'(2'b01));
        chk("pass_valid", 192'(EX_VALID), 192'(1));

        // 3: load-use on rs1
        drive_idle();
        ID_MEM_READ = 3'b011; ID_REG_WRITE = 1; ID_RD = 5; ID_MEM_TO_REG = 2'b01;
        step("lw_x5");
        drive_idle();
        ID_ALU_OP = 5'b00000; ID_REG_WRITE = 1; ID_RS1 = 5; ID_RS2 = 7; ID_RD = 8;
        #1;
        chk("lu_stall_direct", 192'(LOAD_USE_STALL), 192'(1));
        step("lu_bubble");
        chk("lu_bubble_count", 192'(BUBBLE_COUNT), 192'(1));
        chk("lu_bubble_valid", 192'(EX_VALID), 192'(0));
        step("lu_add");
        chk("lu_add_rs1", 192'(EX_RS1), 192'(5));
        chk("lu_add_valid", 192'(EX_VALID), 192'(1));

        // load to x0 never stalls
        drive_idle();
        ID_MEM_READ = 3'b011; ID_REG_WRITE = 1; ID_RD = 0;
        step("lw_x0");
        drive_idle();
        ID_REG_WRITE = 1; ID_RS1 = 0; ID_RS2 = 0; ID_RD = 9;
        #1;
        chk("x0_no_stall", 192'(LOAD_USE_STALL), 192'(0));
        step("x0_follow");

        // 4: STALL hold with changing ID inputs
        for (int i = 0; i < 3; i++) begin
            drive_random();
            STALL = 1;
            step("stall_hold");
        end
        chk("stall_count_direct", 192'(BUBBLE_COUNT), 192'(1));
        STALL = 0;

        // 5: FLUSH and STALL together with a branch in ID
        drive_idle();
        ID_BRANCH = 1; ID_ALU_OP = 5'b01000; ID_RS1 = 1; ID_RS2 = 2;
        STALL = 1; FLUSH = 1;
        step("flush_stall");
        chk("flush_count_direct", 192'(BUBBLE_COUNT), 192'(2));
        chk("flush_branch_cleared", 192'(EX_BRANCH), 192'(0));

        // 6: saturation of the 2-bit counter
        STALL = 0;
        for (int i = 0; i < 5; i++) begin
            FLUSH = 1;
            step("flush_run");
        end
        chk("sat_count_direct", 192'(s_count), 192'(3));
        chk("wide_count_direct", 192'(BUBBLE_COUNT), 192'(7));
        FLUSH = 0;

        // STALL while a load-use hazard is pending keeps the hazard visible
        drive_idle();
        ID_MEM_READ = 3'b010; ID_REG_WRITE = 1; ID_RD = 4;
        step("lw_x4");
        drive_idle();
        ID_RS2 = 4; STALL = 1;
        step("stall_lu_1");
        step("stall_lu_2");
        STALL = 0;
        step("stall_lu_bubble");
        step("stall_lu_go");

        // random traffic
        for (int i = 0; i < 300; i++) begin
            drive_random();
            STALL = ($urandom_range(0, 5) == 0);
            FLUSH = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
